// File: rtl/param_csa_accum.sv
// Sequential carry-save frame accumulator with optional approximate low columns.
// Optional operand counter output enabled by defining CSA_ACC_COUNT_EN.
module param_csa_accum #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned APPROX_BITS = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             approx_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             cg_en
`ifdef CSA_ACC_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cy;
    logic             frame_approx;

    logic             accept_c;
    logic             approx_sel_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] cout_c;

    assign accept_c     = in_valid & in_ready;
    // The first operand of a frame is compressed with the live approx_en value.
    assign approx_sel_c = (state == IDLE) ? approx_en : frame_approx;
    assign cg_en        = (state != IDLE) | in_valid;

    // One row of full-adder cells; low columns may use the approximate cell.
    always_comb begin
        sum_c  = '0;
        cout_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cout_c[i] = (s[i] & cy[i]) | (s[i] & in_data[i]) | (cy[i] & in_data[i]);
            if (approx_sel_c && ($unsigned(i) < APPROX_BITS)) begin
                sum_c[i] = ~cout_c[i];
            end else begin
                sum_c[i] = s[i] ^ cy[i] ^ in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s            <= '0;
            cy           <= '0;
            frame_approx <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            in_ready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        frame_approx <= approx_en;
                        s            <= sum_c;
                        cy           <= {cout_c[WIDTH-2:0], 1'b0};
                        if (in_last) begin
                            state    <= RESOLVE;
                            in_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end else begin
                        s  <= '0;
                        cy <= '0;
                    end
                end
                ACCUM: begin
                    if (accept_c) begin
                        s  <= sum_c;
                        cy <= {cout_c[WIDTH-2:0], 1'b0};
                        if (in_last) begin
                            state    <= RESOLVE;
                            in_ready <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    out_data  <= s + cy;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        s         <= '0;
                        cy        <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef CSA_ACC_COUNT_EN
    // Saturating count of operands accepted in the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else begin
            case (state)
                IDLE: out_count <= accept_c ? CNT_W'(1) : '0;
                ACCUM: begin
                    if (accept_c && (out_count != {CNT_W{1'b1}})) begin
                        out_count <= out_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_count <= '0;
                    end
                end
                default: out_count <= out_count;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_param_csa_accum.sv
// Self-checking bench for param_csa_accum: directed scenarios plus randomized frames
// checked against a word-level reference model.
module tb_param_csa_accum;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned APPROX_BITS = 4;
    localparam int unsigned CNT_W       = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             approx_en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             cg_en;
`ifdef CSA_ACC_COUNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] frame_q[$];

    always #5 clk = ~clk;

    param_csa_accum #(
        .WIDTH(WIDTH),
        .APPROX_BITS(APPROX_BITS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .approx_en(approx_en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .cg_en(cg_en)
`ifdef CSA_ACC_COUNT_EN
        ,
        .out_count(out_count)
`endif
    );

    // Reference: exact frames are a plain modular sum; approximate frames apply the
    // approximate cell rule to the low columns at word level.
    function automatic logic [WIDTH-1:0] model_sum(input bit apx);
        logic [WIDTH-1:0] total = '0;
        logic [WIDTH-1:0] sv = '0;
        logic [WIDTH-1:0] cv = '0;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] mask;
        if (!apx || APPROX_BITS == 0) begin
            foreach (frame_q[k]) total = total + frame_q[k];
            return total;
        end
        mask = WIDTH'((32'd1 << APPROX_BITS) - 1);
        foreach (frame_q[k]) begin
            x  = sv ^ cv ^ frame_q[k];
            m  = (sv & cv) | (sv & frame_q[k]) | (cv & frame_q[k]);
            sv = (x & ~mask) | (~m & mask);
            cv = m << 1;
        end
        return sv + cv;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [WIDTH-1:0] d, input bit last, input bit apx);
        int guard = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        approx_en = apx;
        while (in_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            n_checks++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input logic [WIDTH-1:0] exp, input string name, input int ready_delay);
        int guard = 0;
        while (out_valid !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL %s_valid_timeout out_valid=%b required 1", name, out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== exp) $display("FAIL %s_data got %h required %h", name, out_data, exp);
        else n_pass++;
        repeat (ready_delay) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s_handshake out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; approx_en = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || cg_en !== 1'b0)
            $display("FAIL reset_state in_ready=%b out_valid=%b out_data=%h cg_en=%b required 0 0 0000 0",
                     in_ready, out_valid, out_data, cg_en);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || cg_en !== 1'b0)
            $display("FAIL post_reset in_ready=%b cg_en=%b required 1 0", in_ready, cg_en);
        else n_pass++;
    endtask

    task automatic test_gating();
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (cg_en !== 1'b1) $display("FAIL cg_en_pending got %b required 1", cg_en);
        else n_pass++;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (cg_en !== 1'b0) $display("FAIL cg_en_idle got %b required 0", cg_en);
        else n_pass++;
    endtask

    task automatic test_exact();
        send_op(16'd3, 1'b0, 1'b0);
        send_op(16'd5, 1'b0, 1'b0);
        send_op(16'd7, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || cg_en !== 1'b1)
            $display("FAIL exact_resolve_cycle out_valid=%b in_ready=%b cg_en=%b required 0 0 1",
                     out_valid, in_ready, cg_en);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL exact_latency out_valid=%b required 1", out_valid);
        else n_pass++;
        get_result(16'd15, "exact", 0);
    endtask

    task automatic test_approx_single();
        send_op(16'h0010, 1'b1, 1'b1);
        get_result(16'h001F, "approx_single", 0);
        send_op(16'h0010, 1'b1, 1'b0);
        get_result(16'h0010, "exact_single", 0);
    endtask

    task automatic test_wrap();
        send_op(16'hFFFF, 1'b0, 1'b0);
        send_op(16'h0002, 1'b1, 1'b0);
        get_result(16'h0001, "wrap", 0);
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp;
        frame_q = {16'h1234, 16'h0F0F, 16'hA5A5};
        exp = model_sum(1'b1);
        foreach (frame_q[k]) send_op(frame_q[k], k == 2, 1'b1);
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0)
                $display("FAIL backpressure_hold cycle %0d out_valid=%b out_data=%h in_ready=%b required 1 %h 0",
                         c, out_valid, out_data, in_ready, exp);
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL backpressure_release out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        else n_pass++;
        in_valid = 1'b1; in_data = 16'h0022; in_last = 1'b1; approx_en = 1'b0;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0022)
            $display("FAIL back_to_back out_valid=%b out_data=%h required 1 0022", out_valid, out_data);
        else n_pass++;
        get_result(16'h0022, "back_to_back", 0);
    endtask

    task automatic test_reset_mid_frame();
        send_op(16'd4, 1'b0, 1'b0);
        send_op(16'd6, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_mid_frame out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
        else n_pass++;
        tick();
        send_op(16'd9, 1'b1, 1'b0);
        get_result(16'd9, "reset_mid_frame", 0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] exp;
        int len;
        bit apx;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 6);
            apx = 1'($urandom_range(0, 1));
            frame_q.delete();
            for (int k = 0; k < len; k++) frame_q.push_back(WIDTH'($urandom()));
            exp = model_sum(apx);
            for (int k = 0; k < len; k++) begin
                send_op(frame_q[k], k == len - 1, (k == 0) ? apx : 1'($urandom_range(0, 1)));
                if (k != len - 1) repeat ($urandom_range(0, 2)) tick();
            end
`ifdef CSA_ACC_COUNT_EN
            tick();
            n_checks++;
            if (out_count !== CNT_W'(len))
                $display("FAIL random_count frame %0d got %0d required %0d", f, out_count, len);
            else n_pass++;
`endif
            get_result(exp, "random", $urandom_range(0, 3));
        end
    endtask

`ifdef CSA_ACC_COUNT_EN
    task automatic test_count();
        for (int k = 0; k < 4; k++) send_op(16'(k + 1), k == 3, 1'b0);
        tick();
        n_checks++;
        if (out_count !== CNT_W'(4)) $display("FAIL count_four got %0d required 4", out_count);
        else n_pass++;
        get_result(16'd10, "count_four", 0);
        for (int k = 0; k < 300; k++) send_op(16'd1, k == 299, 1'b0);
        tick();
        n_checks++;
        if (out_count !== {CNT_W{1'b1}}) $display("FAIL count_saturate got %0d required 255", out_count);
        else n_pass++;
        get_result(16'd300, "count_saturate", 0);
        n_checks++;
        if (out_count !== '0) $display("FAIL count_clear got %0d required 0", out_count);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_gating();
        test_exact();
        test_approx_single();
        test_wrap();
        test_backpressure();
        test_reset_mid_frame();
`ifdef CSA_ACC_COUNT_EN
        test_count();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
